// File: rtl/dec_pkg.sv
// Shared decode definitions for dec_pipe: mode constants, occupancy states and the
// reference decode function (sized for the widest supported select, callers truncate).
package dec_pkg;

  localparam int DEC_SEL_MAX_W = 8;
  localparam int DEC_OUT_MAX_W = 2 ** DEC_SEL_MAX_W;

  localparam logic DEC_MODE_ONEHOT = 1'b0;
  localparam logic DEC_MODE_THERM  = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dec_state_e;

  function automatic logic [DEC_OUT_MAX_W-1:0] dec_word(
    input logic [DEC_SEL_MAX_W-1:0] sel,
    input logic                     en,
    input logic                     mode
  );
    logic [DEC_OUT_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < DEC_OUT_MAX_W; i++) begin
      if (mode == DEC_MODE_THERM) w[i] = en & (i <= int'(sel));
      else                        w[i] = en & (i == int'(sel));
    end
    return w;
  endfunction

endpackage

// File: rtl/dec_stage.sv
// One storage entry of the decode pipeline: valid flag plus decoded word and echoed select.
// Load has priority over clear so a same-edge replace keeps the entry occupied.
module dec_stage
  import dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [OUT_W-1:0] i_dec,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_vld,
  output logic [OUT_W-1:0] o_dec,
  output logic [SEL_W-1:0] o_sel
);

  logic             r_vld;
  logic [OUT_W-1:0] r_dec;
  logic [SEL_W-1:0] r_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dec <= '0;
      r_sel <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dec <= i_dec;
      r_sel <= i_sel;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dec = r_dec;
  assign o_sel = r_sel;

endmodule

// File: rtl/dec_pipe.sv
// Pipelined SEL_W-to-2^SEL_W one-hot/thermometer decoder with valid/ready on both sides.
// Define DEC_SKID_EN for a 2-entry skid build with registered in_ready; default is one register.
module dec_pipe
  import dec_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_en,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**SEL_W)-1:0] out_dec,
  output logic [SEL_W-1:0]      out_sel
);

  localparam int OUT_W = 2 ** SEL_W;

  dec_state_e       r_state;
  dec_state_e       w_state_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OUT_W-1:0] w_in_dec;
  logic             w_s0_vld;
  logic [OUT_W-1:0] w_s0_dec;
  logic [SEL_W-1:0] w_s0_sel;
  logic             w_s0_load;
  logic             w_s0_clr;
  logic [OUT_W-1:0] w_s0_dec_d;
  logic [SEL_W-1:0] w_s0_sel_d;

  // Input-side decode is purely combinational; only registered results reach the outputs.
  assign w_in_dec   = OUT_W'(dec_word(DEC_SEL_MAX_W'(in_sel), in_en, in_mode));
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_s0_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  dec_stage #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_out (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_s0_load),
    .i_clr  (w_s0_clr),
    .i_dec  (w_s0_dec_d),
    .i_sel  (w_s0_sel_d),
    .o_vld  (w_s0_vld),
    .o_dec  (w_s0_dec),
    .o_sel  (w_s0_sel)
  );

`ifdef DEC_SKID_EN
  logic             w_s1_vld;
  logic [OUT_W-1:0] w_s1_dec;
  logic [SEL_W-1:0] w_s1_sel;
  logic             w_s1_load;
  logic             w_s1_clr;

  dec_stage #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_s1_load),
    .i_clr  (w_s1_clr),
    .i_dec  (w_in_dec),
    .i_sel  (in_sel),
    .o_vld  (w_s1_vld),
    .o_dec  (w_s1_dec),
    .o_sel  (w_s1_sel)
  );

  // Ready comes from the state register only, so it never depends on out_ready.
  assign in_ready = !rst & (r_state != FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_s0_load   = 1'b0;
    w_s0_clr    = 1'b0;
    w_s1_load   = 1'b0;
    w_s1_clr    = 1'b0;
    w_s0_dec_d  = w_in_dec;
    w_s0_sel_d  = in_sel;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_s0_load   = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_s0_load = 1'b1;
        end else if (w_in_xfer) begin
          w_s1_load   = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_xfer) begin
          w_s0_clr    = 1'b1;
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          w_s0_load   = 1'b1;
          w_s0_dec_d  = w_s1_dec;
          w_s0_sel_d  = w_s1_sel;
          w_s1_clr    = 1'b1;
          w_state_nxt = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  logic w_unused;
  assign w_unused = w_s1_vld;
`else
  // Single register: accept whenever the slot is free or is being drained this cycle.
  assign in_ready = !rst & (!w_s0_vld | out_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_s0_load   = 1'b0;
    w_s0_clr    = 1'b0;
    w_s0_dec_d  = w_in_dec;
    w_s0_sel_d  = in_sel;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_s0_load   = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_in_xfer) begin
          w_s0_load = 1'b1;
        end else if (w_out_xfer) begin
          w_s0_clr    = 1'b1;
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end
`endif

  assign out_valid = w_s0_vld;
  assign out_dec   = w_s0_dec;
  assign out_sel   = w_s0_sel;

endmodule
